fetch_control_sequencer: RTL and testbench

Control sequencer for the 19-bit CPU. It drives the LOAD/INC/CLR strobes of the PC, AR and IR instances of the 19-bit register block (captured on CLK rising edge). It also runs a memory read handshake and hands each decoded instruction to the execute unit.
It sits directly upstream of the register file: every register control input in the datapath originates here.

---
 rtl/cpu19_pkg.sv | 39 +++
 rtl/seq_ack_watchdog.sv | 38 +++
 rtl/fetch_control_sequencer.sv | 163 ++++++++++++++++
 tb/tb_fetch_control_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu19_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu19_pkg
//  Brief    : Shared widths, sequencer state encodings, AR source select
//             codes and opcode helpers for the 19-bit CPU.
//  Revision : 1.0  initial release
// ============================================================================
package cpu19_pkg;

   localparam int DATA_W = 19;
   localparam int ADDR_W = 14;
   localparam int OP_W   = 4;

   localparam logic [OP_W-1:0] HALT_OP = 4'hF;

   // Sequencer states; the encoding is visible on the debug STATE port.
   typedef enum logic [2:0] {
      S_CLEAR     = 3'd0,
      S_IDLE      = 3'd1,
      S_FETCH_AR  = 3'd2,
      S_FETCH_MEM = 3'd3,
      S_DECODE    = 3'd4,
      S_INDIRECT  = 3'd5,
      S_EXEC_WAIT = 3'd6,
      S_HALT      = 3'd7
   } seq_state_e;

   // AR source mux select codes
   localparam logic [1:0] SEL_PC  = 2'd0;
   localparam logic [1:0] SEL_IR  = 2'd1;
   localparam logic [1:0] SEL_MEM = 2'd2;

   // Opcode field lives in the top OP_W bits of the instruction word.
   function automatic logic [OP_W-1:0] ir_opcode(input logic [DATA_W-1:0] ir);
      return ir[DATA_W-1 -: OP_W];
   endfunction

endpackage
`default_nettype wire

// File: rtl/seq_ack_watchdog.sv
`default_nettype none
// ============================================================================
//  Module   : seq_ack_watchdog
//  Brief    : Counts cycles spent waiting for a memory acknowledge and flags
//             the last permitted cycle so the sequencer can abort.
//  Revision : 1.0  initial release
// ============================================================================
module seq_ack_watchdog #(
   parameter int ACK_TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic timeout
);

   localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] c_last = CNT_W'(ACK_TIMEOUT - 1);

   logic [CNT_W-1:0] r_count;

   // Wait counter: held at zero outside wait states, counts unacked cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_count <= '0;
      end else if (clr) begin
         r_count <= '0;
      end else if (en) begin
         r_count <= r_count + 1'b1;
      end
   end

   // Flag is raised during the final cycle an ack can still arrive in time.
   assign timeout = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/fetch_control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_control_sequencer
//  Brief    : Fetch/decode control sequencer driving PC/AR/IR strobes, the
//             memory read handshake and the execute-unit handoff.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_control_sequencer
   import cpu19_pkg::*;
#(
   parameter int ACK_TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic [DATA_W-1:0] ir_in,
   input  logic              mem_ack,
   input  logic              exec_done,
   input  logic              branch_taken,
   output logic              pc_load,
   output logic              pc_inc,
   output logic              pc_clr,
   output logic              ar_load,
   output logic [1:0]        ar_sel,
   output logic              ir_load,
   output logic              mem_rd,
   output logic              exec_start,
   output logic [OP_W-1:0]   opcode,
   output logic              halted,
   output logic              bus_err,
   output logic [2:0]        state
);

   seq_state_e       r_state;
   seq_state_e       w_next_state;
   logic [OP_W-1:0]  r_opcode;
   logic             r_bus_err;
   logic             w_set_err;
   logic             w_wait_state;
   logic             w_timeout;
   logic             w_unused_addr;

   // The address field is consumed by the AR datapath, not by control.
   assign w_unused_addr = ^ir_in[ADDR_W-1:0];

   assign w_wait_state = (r_state == S_FETCH_MEM) || (r_state == S_INDIRECT);

   seq_ack_watchdog #(
      .ACK_TIMEOUT (ACK_TIMEOUT)
   ) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .clr     (!w_wait_state),
      .en      (w_wait_state && !mem_ack),
      .timeout (w_timeout)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_CLEAR;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Opcode capture at decode and sticky bus-error flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_opcode  <= '0;
         r_bus_err <= 1'b0;
      end else begin
         if (r_state == S_DECODE) begin
            r_opcode <= ir_opcode(ir_in);
         end
         if (w_set_err) begin
            r_bus_err <= 1'b1;
         end
      end
   end

   // Next-state and strobe decode; handshake strobes are Mealy on ack/done
   always_comb begin
      w_next_state = r_state;
      w_set_err    = 1'b0;
      pc_load      = 1'b0;
      pc_inc       = 1'b0;
      pc_clr       = 1'b0;
      ar_load      = 1'b0;
      ar_sel       = SEL_PC;
      ir_load      = 1'b0;
      mem_rd       = 1'b0;
      exec_start   = 1'b0;
      halted       = 1'b0;
      case (r_state)
         S_CLEAR: begin
            pc_clr       = 1'b1;
            w_next_state = S_IDLE;
         end
         S_IDLE: begin
            if (run) begin
               w_next_state = S_FETCH_AR;
            end
         end
         S_FETCH_AR: begin
            ar_load      = 1'b1;
            ar_sel       = SEL_PC;
            w_next_state = S_FETCH_MEM;
         end
         S_FETCH_MEM: begin
            mem_rd = 1'b1;
            // An ack on the timeout cycle still completes normally.
            if (mem_ack) begin
               ir_load      = 1'b1;
               pc_inc       = 1'b1;
               w_next_state = S_DECODE;
            end else if (w_timeout) begin
               w_set_err    = 1'b1;
               w_next_state = S_HALT;
            end
         end
         S_DECODE: begin
            if (ir_opcode(ir_in) == HALT_OP) begin
               w_next_state = S_HALT;
            end else begin
               ar_load      = 1'b1;
               ar_sel       = SEL_IR;
               w_next_state = ir_in[ADDR_W] ? S_INDIRECT : S_EXEC_WAIT;
            end
         end
         S_INDIRECT: begin
            mem_rd = 1'b1;
            ar_sel = SEL_MEM;
            if (mem_ack) begin
               ar_load      = 1'b1;
               w_next_state = S_EXEC_WAIT;
            end else if (w_timeout) begin
               w_set_err    = 1'b1;
               w_next_state = S_HALT;
            end
         end
         S_EXEC_WAIT: begin
            exec_start = 1'b1;
            if (exec_done) begin
               pc_load      = branch_taken;
               w_next_state = run ? S_FETCH_AR : S_IDLE;
            end
         end
         S_HALT: begin
            halted = 1'b1;
         end
         default: begin
            w_next_state = S_CLEAR;
         end
      endcase
   end

   assign opcode  = r_opcode;
   assign bus_err = r_bus_err;
   assign state   = r_state;

endmodule
`default_nettype wire

// File: tb/tb_fetch_control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_control_sequencer
//  Brief    : Scoreboard bench for the fetch control sequencer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_control_sequencer;

   typedef struct packed {
      logic [2:0] st;
      logic [3:0] op;
      logic       pl, pi, pc, al;
      logic [1:0] sel;
      logic       il, rd, es, h, be;
   } outv_t;

   typedef struct {
      logic        run, ack, done, br;
      logic [18:0] ir;
      outv_t       e;
   } stim_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        run = 1'b0;
   logic [18:0] ir_in = '0;
   logic        mem_ack = 1'b0;
   logic        exec_done = 1'b0;
   logic        branch_taken = 1'b0;
   logic        pc_load, pc_inc, pc_clr, ar_load, ir_load, mem_rd, exec_start;
   logic        halted, bus_err;
   logic [1:0]  ar_sel;
   logic [3:0]  opcode;
   logic [2:0]  state;

   int    total = 0;
   int    bad = 0;
   outv_t sb[$];
   outv_t got, want;

   fetch_control_sequencer #(.ACK_TIMEOUT(16)) dut (
      .clk          (clk),
      .rst          (rst),
      .run          (run),
      .ir_in        (ir_in),
      .mem_ack      (mem_ack),
      .exec_done    (exec_done),
      .branch_taken (branch_taken),
      .pc_load      (pc_load),
      .pc_inc       (pc_inc),
      .pc_clr       (pc_clr),
      .ar_load      (ar_load),
      .ar_sel       (ar_sel),
      .ir_load      (ir_load),
      .mem_rd       (mem_rd),
      .exec_start   (exec_start),
      .opcode       (opcode),
      .halted       (halted),
      .bus_err      (bus_err),
      .state        (state)
   );

   always #5 clk = ~clk;

   function automatic outv_t outs();
      return '{state, opcode, pc_load, pc_inc, pc_clr, ar_load, ar_sel,
               ir_load, mem_rd, exec_start, halted, bus_err};
   endfunction

   function automatic outv_t mk(input logic [2:0] st, input logic [3:0] op,
                                input logic pl, pi, pc, al, input logic [1:0] sel,
                                input logic il, rd, es, h, be);
      return '{st, op, pl, pi, pc, al, sel, il, rd, es, h, be};
   endfunction

   function automatic stim_t s(input logic r, a, d, b, input logic [18:0] ir,
                               input outv_t e);
      stim_t t;
      t.run = r; t.ack = a; t.done = d; t.br = b; t.ir = ir; t.e = e;
      return t;
   endfunction

   // Reset: async check while asserted, then CLEAR one cycle, then IDLE
   task automatic test_reset();
      stim_t sq[$];
      rst = 1'b1; run = 1'b0; mem_ack = 1'b0; exec_done = 1'b0;
      branch_taken = 1'b0; ir_in = '0;
      #1;
      got = outs(); want = mk(0, 0, 0,0,1,0, 2'd0, 0,0,0,0,0); total++;
      if (got !== want) begin
         bad++; $display("FAIL reset_async: got=%h want=%h", got, want);
      end
      @(posedge clk); #1; rst = 1'b0;
      sq.push_back(s(0,0,0,0,19'h0, mk(0,0, 0,0,1,0, 2'd0, 0,0,0,0,0)));
      sq.push_back(s(0,0,0,0,19'h0, mk(1,0, 0,0,0,0, 2'd0, 0,0,0,0,0)));
      sq.push_back(s(0,1,1,0,19'h0, mk(1,0, 0,0,0,0, 2'd0, 0,0,0,0,0)));
      foreach (sq[i]) begin
         run = sq[i].run; mem_ack = sq[i].ack; exec_done = sq[i].done;
         branch_taken = sq[i].br; ir_in = sq[i].ir; sb.push_back(sq[i].e);
         @(negedge clk);
         got = outs(); want = sb.pop_front(); total++;
         if (got !== want) begin
            bad++; $display("FAIL reset[%0d]: got=%h want=%h", i, got, want);
         end
         @(posedge clk); #1;
      end
   endtask

   // Zero-wait fetch of a direct instruction, left waiting in EXEC_WAIT
   task automatic test_direct_fetch();
      stim_t sq[$];
      sq.push_back(s(1,0,0,0,19'h0,     mk(1,0, 0,0,0,0, 2'd0, 0,0,0,0,0)));
      sq.push_back(s(1,0,0,0,19'h0,     mk(2,0, 0,0,0,1, 2'd0, 0,0,0,0,0)));
      sq.push_back(s(1,1,0,0,19'h1092D, mk(3,0, 0,1,0,0, 2'd0, 1,1,0,0,0)));
      sq.push_back(s(1,0,0,0,19'h1092D, mk(4,0, 0,0,0,1, 2'd1, 0,0,0,0,0)));
      sq.push_back(s(1,0,0,0,19'h1092D, mk(6,2, 0,0,0,0, 2'd0, 0,0,1,0,0)));
      sq.push_back(s(1,1,0,0,19'h1092D, mk(6,2, 0,0,0,0, 2'd0, 0,0,1,0,0)));
      foreach (sq[i]) begin
         run = sq[i].run; mem_ack = sq[i].ack; exec_done = sq[i].done;
         branch_taken = sq[i].br; ir_in = sq[i].ir; sb.push_back(sq[i].e);
         @(negedge clk);
         got = outs(); want = sb.pop_front(); total++;
         if (got !== want) begin
            bad++; $display("FAIL direct_fetch[%0d]: got=%h want=%h", i, got, want);
         end
         @(posedge clk); #1;
      end
   endtask

   // Taken branch with RUN=1 refetches; taken branch with RUN=0 idles
   task automatic test_branch();
      stim_t sq[$];
      sq.push_back(s(1,0,1,1,19'h1092D, mk(6,2, 1,0,0,0, 2'd0, 0,0,1,0,0)));
      sq.push_back(s(1,0,0,0,19'h1092D, mk(2,2, 0,0,0,1, 2'd0, 0,0,0,0,0)));
      sq.push_back(s(1,1,0,0,19'h1092D, mk(3,2, 0,1,0,0, 2'd0, 1,1,0,0,0)));
      sq.push_back(s(1,0,0,0,19'h1092D, mk(4,2, 0,0,0,1, 2'd1, 0,0,0,0,0)));
      sq.push_back(s(0,0,1,1,19'h1092D, mk(6,2, 1,0,0,0, 2'd0, 0,0,1,0,0)));
      sq.push_back(s(0,0,0,0,19'h1092D, mk(1,2, 0,0,0,0, 2'd0, 0,0,0,0,0)));
      foreach (sq[i]) begin
         run = sq[i].run; mem_ack = sq[i].ack; exec_done = sq[i].done;
         branch_taken = sq[i].br; ir_in = sq[i].ir; sb.push_back(sq[i].e);
         @(negedge clk);
         got = outs(); want = sb.pop_front(); total++;
         if (got !== want) begin
            bad++; $display("FAIL branch[%0d]: got=%h want=%h", i, got, want);
         end
         @(posedge clk); #1;
      end
   endtask

   // Indirect instruction with one fetch wait state and three indirect waits
   task automatic test_indirect();
      stim_t sq[$];
      sq.push_back(s(1,0,0,0,19'h0,     mk(1,2, 0,0,0,0, 2'd0, 0,0,0,0,0)));
      sq.push_back(s(1,0,0,0,19'h0,     mk(2,2, 0,0,0,1, 2'd0, 0,0,0,0,0)));
      sq.push_back(s(1,0,1,0,19'h0,     mk(3,2, 0,0,0,0, 2'd0, 0,1,0,0,0)));
      sq.push_back(s(1,1,0,0,19'h1C100, mk(3,2, 0,1,0,0, 2'd0, 1,1,0,0,0)));
      sq.push_back(s(1,0,0,0,19'h1C100, mk(4,2, 0,0,0,1, 2'd1, 0,0,0,0,0)));
      for (int k = 0; k < 3; k++)
         sq.push_back(s(1,0,0,0,19'h1C100, mk(5,3, 0,0,0,0, 2'd2, 0,1,0,0,0)));
      sq.push_back(s(1,1,0,0,19'h1C100, mk(5,3, 0,0,0,1, 2'd2, 0,1,0,0,0)));
      sq.push_back(s(1,1,0,0,19'h1C100, mk(6,3, 0,0,0,0, 2'd0, 0,0,1,0,0)));
      sq.push_back(s(0,0,1,0,19'h1C100, mk(6,3, 0,0,0,0, 2'd0, 0,0,1,0,0)));
      sq.push_back(s(0,1,0,0,19'h1C100, mk(1,3, 0,0,0,0, 2'd0, 0,0,0,0,0)));
      foreach (sq[i]) begin
         run = sq[i].run; mem_ack = sq[i].ack; exec_done = sq[i].done;
         branch_taken = sq[i].br; ir_in = sq[i].ir; sb.push_back(sq[i].e);
         @(negedge clk);
         got = outs(); want = sb.pop_front(); total++;
         if (got !== want) begin
            bad++; $display("FAIL indirect[%0d]: got=%h want=%h", i, got, want);
         end
         @(posedge clk); #1;
      end
   endtask

   // HALT opcode: no AR load in decode, terminal regardless of inputs
   task automatic test_halt();
      stim_t sq[$];
      sq.push_back(s(1,0,0,0,19'h0,     mk(1,3, 0,0,0,0, 2'd0, 0,0,0,0,0)));
      sq.push_back(s(1,0,0,0,19'h0,     mk(2,3, 0,0,0,1, 2'd0, 0,0,0,0,0)));
      sq.push_back(s(1,1,0,0,19'h78000, mk(3,3, 0,1,0,0, 2'd0, 1,1,0,0,0)));
      sq.push_back(s(1,0,0,0,19'h78000, mk(4,3, 0,0,0,0, 2'd0, 0,0,0,0,0)));
      sq.push_back(s(1,1,1,1,19'h78000, mk(7,15, 0,0,0,0, 2'd0, 0,0,0,1,0)));
      sq.push_back(s(0,1,0,0,19'h0,     mk(7,15, 0,0,0,0, 2'd0, 0,0,0,1,0)));
      foreach (sq[i]) begin
         run = sq[i].run; mem_ack = sq[i].ack; exec_done = sq[i].done;
         branch_taken = sq[i].br; ir_in = sq[i].ir; sb.push_back(sq[i].e);
         @(negedge clk);
         got = outs(); want = sb.pop_front(); total++;
         if (got !== want) begin
            bad++; $display("FAIL halt[%0d]: got=%h want=%h", i, got, want);
         end
         @(posedge clk); #1;
      end
   endtask

   // 16 unacked FETCH_MEM cycles end in HALT with a sticky bus error
   task automatic test_timeout();
      stim_t sq[$];
      sq.push_back(s(1,0,0,0,19'h0, mk(1,0, 0,0,0,0, 2'd0, 0,0,0,0,0)));
      sq.push_back(s(1,0,0,0,19'h0, mk(2,0, 0,0,0,1, 2'd0, 0,0,0,0,0)));
      for (int k = 0; k < 16; k++)
         sq.push_back(s(1,0,0,0,19'h0, mk(3,0, 0,0,0,0, 2'd0, 0,1,0,0,0)));
      sq.push_back(s(1,1,0,0,19'h0, mk(7,0, 0,0,0,0, 2'd0, 0,0,0,1,1)));
      sq.push_back(s(0,0,0,0,19'h0, mk(7,0, 0,0,0,0, 2'd0, 0,0,0,1,1)));
      foreach (sq[i]) begin
         run = sq[i].run; mem_ack = sq[i].ack; exec_done = sq[i].done;
         branch_taken = sq[i].br; ir_in = sq[i].ir; sb.push_back(sq[i].e);
         @(negedge clk);
         got = outs(); want = sb.pop_front(); total++;
         if (got !== want) begin
            bad++; $display("FAIL timeout[%0d]: got=%h want=%h", i, got, want);
         end
         @(posedge clk); #1;
      end
   endtask

   // Ack arriving on the 16th FETCH_MEM cycle wins over the timeout
   task automatic test_ack_boundary();
      stim_t sq[$];
      sq.push_back(s(1,0,0,0,19'h0, mk(1,0, 0,0,0,0, 2'd0, 0,0,0,0,0)));
      sq.push_back(s(1,0,0,0,19'h0, mk(2,0, 0,0,0,1, 2'd0, 0,0,0,0,0)));
      for (int k = 0; k < 15; k++)
         sq.push_back(s(1,0,0,0,19'h0, mk(3,0, 0,0,0,0, 2'd0, 0,1,0,0,0)));
      sq.push_back(s(1,1,0,0,19'h1092D, mk(3,0, 0,1,0,0, 2'd0, 1,1,0,0,0)));
      sq.push_back(s(1,0,0,0,19'h1092D, mk(4,0, 0,0,0,1, 2'd1, 0,0,0,0,0)));
      sq.push_back(s(1,0,0,0,19'h1092D, mk(6,2, 0,0,0,0, 2'd0, 0,0,1,0,0)));
      foreach (sq[i]) begin
         run = sq[i].run; mem_ack = sq[i].ack; exec_done = sq[i].done;
         branch_taken = sq[i].br; ir_in = sq[i].ir; sb.push_back(sq[i].e);
         @(negedge clk);
         got = outs(); want = sb.pop_front(); total++;
         if (got !== want) begin
            bad++; $display("FAIL ack_boundary[%0d]: got=%h want=%h", i, got, want);
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      #1;
      @(posedge clk); #1;
      test_reset();
      test_direct_fetch();
      test_branch();
      test_indirect();
      test_halt();
      test_reset();
      test_timeout();
      test_reset();
      test_ack_boundary();
      test_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL time_limit: got=running want=finished");
      $fatal(1, "time limit");
   end

endmodule
`default_nettype wire
